// File: rtl/multisim_axi_mem_sub.sv
// multisim_axi_mem_sub: AXI4 subordinate memory model.
// Independent write (AW/W/B) and read (AR/R) engines share a word-addressed
// array. INCR bursts only, byte strobes on writes, SLVERR for out-of-range
// beats and for wlast placement errors.
//
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where valid and ready are both high. A source holds its payload stable while
// valid is high and ready is low. This block never makes a ready depend on the
// matching valid.
module multisim_axi_mem_sub #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int MW    = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // Backing store; deliberately not reset.
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wstate_t               r_wstate, w_wstate_nxt;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [ADDR_WIDTH-1:0] r_widx;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wcnt;
    logic                  r_werr;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp;

    logic w_aw_fire;
    logic w_w_fire;
    logic w_wbeat_last;
    logic w_w_inrange;
    logic w_wbeat_err;
    logic w_mem_we;

    assign w_aw_fire    = o_awready & i_awvalid;
    assign w_w_fire     = o_wready & i_wvalid;
    assign w_wbeat_last = (r_wcnt == r_wlen);
    assign w_w_inrange  = (r_widx < LIMIT);
    // A beat is bad if it falls outside the array or wlast disagrees with the count.
    assign w_wbeat_err  = !w_w_inrange || (i_wlast != w_wbeat_last);
    assign w_mem_we     = w_w_fire & w_w_inrange;

    assign o_bid   = r_bid;
    assign o_bresp = r_bresp;

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state and channel readies/valid.
    always_comb begin
        w_wstate_nxt = r_wstate;
        o_awready    = 1'b0;
        o_wready     = 1'b0;
        o_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                o_awready = 1'b1;
                if (i_awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                o_wready = 1'b1;
                if (i_wvalid && w_wbeat_last) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write burst bookkeeping: latch AW, step index/count per beat, build B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awid  <= '0;
            r_widx  <= '0;
            r_wlen  <= '0;
            r_wcnt  <= '0;
            r_werr  <= 1'b0;
            r_bid   <= '0;
            r_bresp <= RESP_OKAY;
        end else if (w_aw_fire) begin
            r_awid <= i_awid;
            r_widx <= i_awaddr >> SHIFT;
            r_wlen <= i_awlen;
            r_wcnt <= '0;
            r_werr <= 1'b0;
        end else if (w_w_fire) begin
            r_widx <= r_widx + 1'b1;
            r_wcnt <= r_wcnt + 8'd1;
            if (w_wbeat_last) begin
                r_bid   <= r_awid;
                r_bresp <= (r_werr || w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                r_werr  <= r_werr | w_wbeat_err;
            end
        end
    end

    // Byte-masked array write for in-range beats.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_wstrb[b]) r_mem[r_widx[MW-1:0]][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rstate_t               r_rstate, w_rstate_nxt;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [ADDR_WIDTH-1:0] r_ridx;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rcnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;

    logic                  w_ar_fire;
    logic                  w_r_fire;
    logic                  w_rd_load;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_rd_inrange;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [7:0]            w_rd_cnt;
    logic [7:0]            w_rd_len;

    assign w_ar_fire    = o_arready & i_arvalid;
    assign w_r_fire     = o_rvalid & i_rready;
    // A beat is loaded on AR acceptance and on each handshake that has beats left.
    assign w_rd_load    = w_ar_fire || (w_r_fire && !r_rlast);
    assign w_rd_idx     = w_ar_fire ? (i_araddr >> SHIFT) : r_ridx;
    assign w_rd_cnt     = w_ar_fire ? 8'd0 : (r_rcnt + 8'd1);
    assign w_rd_len     = w_ar_fire ? i_arlen : r_rlen;
    assign w_rd_inrange = (w_rd_idx < LIMIT);
    // Sampled at the edge, so a same-edge write to this word is not visible yet.
    assign w_rd_word    = r_mem[w_rd_idx[MW-1:0]];

    assign o_rid   = r_rid;
    assign o_rdata = r_rdata;
    assign o_rresp = r_rresp;
    assign o_rlast = r_rlast;

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state and AR ready / R valid.
    always_comb begin
        w_rstate_nxt = r_rstate;
        o_arready    = 1'b0;
        o_rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                o_arready = 1'b1;
                if (i_arvalid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                o_rvalid = 1'b1;
                if (i_rready && r_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read beat register: loads beat 0 on AR, then the next beat per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rid   <= '0;
            r_ridx  <= '0;
            r_rlen  <= '0;
            r_rcnt  <= '0;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
            r_rlast <= 1'b0;
        end else if (w_rd_load) begin
            if (w_ar_fire) begin
                r_rid  <= i_arid;
                r_rlen <= i_arlen;
            end
            r_ridx  <= w_rd_idx + 1'b1;
            r_rcnt  <= w_rd_cnt;
            r_rdata <= w_rd_inrange ? w_rd_word : '0;
            r_rresp <= w_rd_inrange ? RESP_OKAY : RESP_SLVERR;
            r_rlast <= (w_rd_cnt == w_rd_len);
        end else if (w_r_fire) begin
            r_rlast <= 1'b0;
        end
    end

endmodule

// File: doc/multisim_axi_mem_sub.md
Name: multisim_axi_mem_sub

Overview:
- AXI4 subordinate memory model that sits directly downstream of the multisim AXI pull client.
- Consumes the AW/W/AR requests the client replays from the server, and produces B/R responses that the client pushes back to the server.
- Backed by a word-addressed array; supports INCR bursts, byte strobes and error responses.
- Independent write and read engines run concurrently.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 64, data bus width in bits (power of two, >=8)
ID_WIDTH, 4, transaction ID width
MEM_WORDS, 1024, number of DATA_WIDTH words in the array

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_awid  in  ID_WIDTH  write ID
i_awaddr  in  ADDR_WIDTH  write start byte address
i_awlen  in  8  beats minus one
i_awvalid  in  1  AW valid
o_awready  out  1  AW ready
i_wdata  in  DATA_WIDTH  write data
i_wstrb  in  DATA_WIDTH/8  byte strobes
i_wlast  in  1  last write beat
i_wvalid  in  1  W valid
o_wready  out  1  W ready
o_bid  out  ID_WIDTH  response ID
o_bresp  out  2  00 OKAY, 10 SLVERR
o_bvalid  out  1  B valid
i_bready  in  1  B ready
i_arid  in  ID_WIDTH  read ID
i_araddr  in  ADDR_WIDTH  read start byte address
i_arlen  in  8  beats minus one
i_arvalid  in  1  AR valid
o_arready  out  1  AR ready
o_rid  out  ID_WIDTH  read ID
o_rdata  out  DATA_WIDTH  read data
o_rresp  out  2  per-beat response
o_rlast  out  1  last read beat
o_rvalid  out  1  R valid
i_rready  in  1  R ready

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - o_awready=1, o_arready=1.
  - o_wready, o_bvalid, o_rvalid, o_rlast = 0.
  - o_bid, o_bresp, o_rid, o_rdata, o_rresp = 0.
  - Both FSMs go to IDLE. Array contents are not reset.
- Reset mid-burst abandons the burst. No partial response is issued. Beats already written stay in the array.
- Word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored (aligned access only). Each beat adds 1 to the index.
- A beat is out of range if its index >= MEM_WORDS. Index arithmetic is ADDR_WIDTH wide and wraps at 2^ADDR_WIDTH with no 4KB check.
- Write FSM, IDLE -> WDATA -> WRESP -> IDLE:
  - IDLE: o_awready=1. On AW handshake, latch id, index and len; set err=0; next state WDATA.
  - WDATA: o_wready=1. On each W handshake with an in-range index, write the bytes enabled by wstrb; bytes with strobe 0 are unchanged.
  - Out-of-range beat: no write, err=1.
  - Burst ends on the beat where the beat counter == len.
  - i_wlast must match the final beat. A mismatch (early wlast, or missing wlast on the final beat) sets err=1. On early wlast the engine still consumes len+1 beats.
  - WRESP: o_bvalid=1, o_bid=latched id, o_bresp = err ? 10 : 00. o_bvalid holds until i_bready, then IDLE.
  - Earliest o_bvalid: the cycle after the last W handshake. Earliest next o_awready: the cycle after the B handshake.
- Read FSM, IDLE -> RDATA -> IDLE:
  - IDLE: o_arready=1. On AR handshake, register beat 0 into o_rdata/o_rresp/o_rlast and set o_rvalid=1 in the next cycle (1-cycle latency).
  - RDATA: R outputs are stable while o_rvalid & !i_rready. On R handshake with beats remaining, load the next beat in the same edge (back-to-back, one beat per cycle).
  - On the o_rlast handshake: o_rvalid=0, return to IDLE.
  - Out-of-range beat: o_rdata=0, o_rresp=10. Otherwise o_rresp=00. o_rlast=1 only on beat len.
- Simultaneous events:
  - A write to word k and a read beat loading word k on the same edge: the read returns pre-write data.
  - AW and AR accepted in the same cycle are both taken.
- Write and read engines are independent; one outstanding transaction per direction; no reordering.

Test Plan:
- Single write: AW id=3 addr=0x10 len=0, W data=0x1122334455667788 strb=0xFF last=1 -> B id=3 resp=00 one cycle after the W handshake. AR id=5 addr=0x10 len=0 -> R id=5 data=0x1122334455667788 rlast=1 resp=00, rvalid asserted the cycle after the AR handshake.
- Burst with strobes:
  - Write 4 beats at 0x100, data 0xA0..0xA3, strb=0x0F on beat 2 over a prior 0xFFFFFFFFFFFFFFFF.
  - Read len=3 -> beats 0xA0, 0xA1, 0xFFFFFFFF000000A2, 0xA3; rlast only on beat 3.
- R backpressure: hold i_rready=0 for 3 cycles mid-burst -> o_rdata/o_rlast/o_rid stable, no beat skipped or repeated. Then i_rready=1 -> one beat per cycle.
- Error paths:
  - Write len=1 starting at word MEM_WORDS-1 -> B resp=10, and word MEM_WORDS-1 is written.
  - Write with wlast on beat 0 of a len=2 burst -> resp=10.
  - Read at word MEM_WORDS -> data 0, resp=10.
- Concurrency and reset:
  - AW and AR in the same cycle to the same word: the first R beat returns old data, and a later read returns new data.
  - Assert rst during a 4-beat write after beat 1 -> o_bvalid never asserts, o_awready=1 after reset, and the 2 beats already written are retained.
